// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared widths, FSM encoding and saturation limits for the FIR tap sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fir_seq_pkg;

  // Default widths; the top exposes each of these as an overridable parameter.
  localparam int DEF_DATA_W = 12;
  localparam int DEF_COEF_W = 12;
  localparam int DEF_TAPS   = 32;
  localparam int DEF_TAP_W  = 5;
  localparam int DEF_OUT_W  = 16;
  localparam int DEF_SHIFT  = 11;
  localparam int DEF_ACC_W  = DEF_DATA_W + DEF_COEF_W + DEF_TAP_W;

  // Saturation limits of the default output width.
  localparam int SAT_MAX = (2 ** (DEF_OUT_W - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (DEF_OUT_W - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: registered sample operand, pipe-valid, signed multiply and accumulator.
// Latency: a product issued on i_issue lands in o_acc two edges later.
// Backpressure: none; the sequencer paces issues.
// Ports: i_clk, i_rst_n (sync, active-low), i_clr (zero acc), i_issue (tap issued this cycle),
//        i_sample (delay-line word for the issued tap), i_coef (memory data, one cycle after issue),
//        o_acc (running sum), o_pipe_vld (a product is pending this cycle).
module fir_mac_unit #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int ACC_W  = 29
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_issue,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic signed [COEF_W-1:0] i_coef,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic                     o_pipe_vld
);

  logic signed [DATA_W-1:0]        r_sample;
  logic                            r_pipe_vld;
  logic signed [ACC_W-1:0]         r_acc;
  logic signed [DATA_W+COEF_W-1:0] w_prod;
  logic signed [ACC_W-1:0]         w_prod_ext;

  // Full-precision product; the size cast sign-extends into the accumulator width.
  assign w_prod     = r_sample * i_coef;
  assign w_prod_ext = ACC_W'(w_prod);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sample   <= '0;
      r_pipe_vld <= 1'b0;
      r_acc      <= '0;
    end else begin
      // The sample register lines up with the coefficient the memory returns one edge later.
      r_pipe_vld <= i_issue;
      if (i_issue) begin
        r_sample <= i_sample;
      end
      if (i_clr) begin
        r_acc <= '0;
      end else if (r_pipe_vld) begin
        r_acc <= r_acc + w_prod_ext;
      end
    end
  end

  assign o_acc      = r_acc;
  assign o_pipe_vld = r_pipe_vld;

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: time-multiplexed FIR; walks coefficient indices and accumulates one output per input.
// Latency: out_valid rises TAPS+2 edges after the accept edge.
// Backpressure: in_ready only in IDLE; y_out held in DONE until out_ready.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/x_in sample input; co_choose/co_in
//        coefficient memory read port (data one cycle after index); out_valid/out_ready/y_out
//        filtered output; busy (not IDLE).
// Build option: FIR_TAP_SEQ_SAT_EN saturates y_out to the OUT_W range instead of wrapping.
module fir_tap_sequencer #(
  parameter int DATA_W = fir_seq_pkg::DEF_DATA_W,
  parameter int COEF_W = fir_seq_pkg::DEF_COEF_W,
  parameter int TAPS   = fir_seq_pkg::DEF_TAPS,
  parameter int TAP_W  = fir_seq_pkg::DEF_TAP_W,
  parameter int ACC_W  = DATA_W + COEF_W + TAP_W,
  parameter int OUT_W  = fir_seq_pkg::DEF_OUT_W,
  parameter int SHIFT  = fir_seq_pkg::DEF_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  output logic [TAP_W-1:0]         co_choose,
  input  logic signed [COEF_W-1:0] co_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  y_out,
  output logic                     busy
);

  import fir_seq_pkg::*;

  seq_state_t               r_state;
  seq_state_t               w_state_next;
  logic signed [DATA_W-1:0] r_line [TAPS];
  logic [TAP_W-1:0]         r_wr_ptr;
  logic [TAP_W-1:0]         r_tap;
  logic signed [OUT_W-1:0]  r_y;

  logic                     w_accept;
  logic                     w_issue;
  logic                     w_load_y;
  logic [TAP_W-1:0]         w_wr_next;
  logic [TAP_W-1:0]         w_rd_idx;
  logic signed [ACC_W-1:0]  w_acc;
  logic                     w_pipe_vld;
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [OUT_W-1:0]  w_y_next;

  // TAPS is a power of two, so pointer arithmetic wraps for free at TAP_W bits.
  assign w_wr_next = r_wr_ptr + TAP_W'(1);
  assign w_rd_idx  = r_wr_ptr - r_tap;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state and outputs ----------------
  // DRAIN waits for the MAC pipe to empty: the last product lands in the
  // accumulator one edge into DRAIN, and y is formed from the settled sum on the
  // following edge as DONE is entered.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_load_y     = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    co_choose    = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_MAC;
        end
      end
      S_MAC: begin
        w_issue   = 1'b1;
        co_choose = r_tap;
        if (r_tap == TAP_W'(TAPS - 1)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_pipe_vld) begin
          w_load_y     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------- Delay line, pointers, output register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_line[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_tap    <= '0;
      r_y      <= '0;
    end else begin
      if (w_accept) begin
        r_line[w_wr_next] <= x_in;
        r_wr_ptr          <= w_wr_next;
        r_tap             <= '0;
      end else if (w_issue) begin
        r_tap <= r_tap + TAP_W'(1);
      end
      if (w_load_y) begin
        r_y <= w_y_next;
      end
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clr      (w_accept),
    .i_issue    (w_issue),
    .i_sample   (r_line[w_rd_idx]),
    .i_coef     (co_in),
    .o_acc      (w_acc),
    .o_pipe_vld (w_pipe_vld)
  );

  // ---------------- Output formatting ----------------
  assign w_shifted = w_acc >>> SHIFT;

`ifdef FIR_TAP_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] L_MAX_EXT = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] L_MIN_EXT = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    w_y_next = OUT_W'(w_shifted);
    if (w_shifted > L_MAX_EXT) begin
      w_y_next = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_shifted < L_MIN_EXT) begin
      w_y_next = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end
`else
  // Two's-complement wrap: keep the low OUT_W bits.
  assign w_y_next = OUT_W'(w_shifted);
`endif

  assign y_out = r_y;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed bench for the FIR tap sequencer.
// Latency: n/a.
// Backpressure: exercised via out_ready holds.
module tb_fir_tap_sequencer;

  localparam int A_ACC = 29;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: SHIFT=0, OUT_W=ACC_W (full-precision view of the accumulator)
  logic                    a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic signed [11:0]      a_x, a_co_in;
  logic [4:0]              a_co_choose;
  logic signed [A_ACC-1:0] a_y;
  logic signed [11:0]      coef_a [32];

  // Instance B: default parameters
  logic                    b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic signed [11:0]      b_x, b_co_in;
  logic [4:0]              b_co_choose;
  logic signed [15:0]      b_y;
  logic signed [11:0]      coef_b [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Coefficient memories: registered read, data one cycle after the index.
  always @(posedge clk) a_co_in <= coef_a[a_co_choose];
  always @(posedge clk) b_co_in <= coef_b[b_co_choose];

  fir_tap_sequencer #(
    .OUT_W (A_ACC),
    .SHIFT (0)
  ) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .x_in      (a_x),
    .co_choose (a_co_choose),
    .co_in     (a_co_in),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .y_out     (a_y),
    .busy      (a_busy)
  );

  fir_tap_sequencer u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .x_in      (b_x),
    .co_choose (b_co_choose),
    .co_in     (b_co_in),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .y_out     (b_y),
    .busy      (b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // One sample through instance A; returns y and the accept-to-out_valid edge count.
  task automatic run_a(input logic signed [11:0] x, input bit trace,
                       output longint y, output int lat);
    a_x        = x;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    lat        = 0;
    if (trace) begin
      for (int t = 0; t < 32; t++) begin
        chk("co_choose_step", a_co_choose, t);
        tick();
        lat++;
      end
      chk("co_choose_drain", a_co_choose, 0);
    end
    while (!a_out_valid && lat < 60) begin
      tick();
      lat++;
    end
    y           = a_y;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic run_b(input logic signed [11:0] x, output longint y, output int lat);
    b_x        = x;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    lat        = 0;
    while (!b_out_valid && lat < 60) begin
      tick();
      lat++;
    end
    y           = b_y;
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  initial begin
    longint y;
    int     lat;

    rst_n       = 1'b0;
    a_in_valid  = 1'b0; a_out_ready = 1'b0; a_x = '0;
    b_in_valid  = 1'b0; b_out_ready = 1'b0; b_x = '0;
    for (int t = 0; t < 32; t++) begin
      coef_a[t] = 12'(t + 1);
      coef_b[t] = 12'sd2047;
    end

    // ---- reset state ----
    tick();
    tick();
    chk("rst_in_ready",  a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_y",         a_y, 0);
    chk("rst_co_choose", a_co_choose, 0);
    chk("rst_busy",      a_busy, 0);
    chk("rst_b_y",       b_y, 0);
    chk("rst_b_busy",    b_busy, 0);
    rst_n = 1'b1;
    tick();

    // ---- impulse: y = 1..32, tap walk traced on the first sample ----
    for (int k = 0; k < 32; k++) begin
      run_a((k == 0) ? 12'sd1 : 12'sd0, (k == 0), y, lat);
      chk("imp_y", y, k + 1);
      chk("imp_lat", lat, 34);
    end

    // ---- handshake: in_valid held while busy, out_ready withheld ----
    do_reset();
    a_x        = 12'sd5;
    a_in_valid = 1'b1;
    tick();
    lat = 0;
    while (!a_out_valid && lat < 60) begin
      chk("hold_busy_no_ready", a_in_ready, 0);
      tick();
      lat++;
    end
    chk("hold_lat", lat, 34);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_out_valid", a_out_valid, 1);
      chk("hold_in_ready", a_in_ready, 0);
      chk("hold_y", a_y, 5);
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b0;
    chk("release_out_valid", a_out_valid, 0);
    chk("release_in_ready", a_in_ready, 1);
    chk("release_busy", a_busy, 0);
    tick();
    tick();
    chk("no_extra_accept", a_busy, 0);

    // ---- reset in the middle of MAC, then impulse reproduces ----
    do_reset();
    a_x        = 12'sd1;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("midmac_tap", a_co_choose, 10);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", a_busy, 0);
    chk("midrst_in_ready", a_in_ready, 1);
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_co_choose", a_co_choose, 0);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      run_a((k == 0) ? 12'sd1 : 12'sd0, 1'b0, y, lat);
      chk("imp2_y", y, k + 1);
      chk("imp2_lat", lat, 34);
    end

    // ---- negative full scale: k samples of -2048 give k * 2^22 ----
    do_reset();
    for (int t = 0; t < 32; t++) coef_a[t] = -12'sd2048;
    for (int k = 1; k <= 32; k++) begin
      run_a(-12'sd2048, 1'b0, y, lat);
      chk("negfs_y", y, longint'(k) * 4194304);
    end

    // ---- default instance: Q11 scaling and wrap/saturate ----
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      run_b(12'sd2047, y, lat);
      if (k == 1) begin
        chk("sat_first_y", y, 2046);
        chk("sat_lat", lat, 34);
      end
    end
`ifdef FIR_TAP_SEQ_SAT_EN
    chk("sat_last_y", y, 32767);
`else
    chk("wrap_last_y", y, -64);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
